seg_stage_scheduler: RTL and testbench

- Sequences the segmentation pipeline compute stages (encode, bottleneck, decode, argmax post-process) through start/done handshakes.
- Replaces ad-hoc per-stage start logic in the top-level processor.
- Supports a per-run stage-enable mask, a per-stage timeout watchdog, abort, and a run cycle counter for profiling.
- Sits between the host/top-level control and the stage engines.

---
 rtl/seg_stage_scheduler.sv | 173 +++++++++++++++++
 tb/tb_seg_stage_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_stage_scheduler.sv
// Sequences the segmentation compute stages through start/done handshakes,
// with a per-run stage mask, per-stage timeout watchdog, abort and a run cycle counter.
module seg_stage_scheduler #(
  parameter int NUM_STAGES = 4,
  parameter int SIDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  parameter int TIMEOUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] cfg_stage_en,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [SIDX_W-1:0]     err_stage,
  output logic [SIDX_W-1:0]     cur_stage,
  output logic [31:0]           run_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH
  } state_t;

  state_t state, state_d;

  logic [SIDX_W-1:0]     cur_d;
  logic [SIDX_W-1:0]     err_stage_d;
  logic                  error_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [TIMEOUT_W-1:0]  timeout_q, timeout_d;
  logic [TIMEOUT_W-1:0]  watchdog, watchdog_d;
  logic [31:0]           run_cycles_d;

  logic                  first_found;
  logic [SIDX_W-1:0]     first_idx;
  logic                  next_found;
  logic [SIDX_W-1:0]     next_idx;
  logic [NUM_STAGES-1:0] cur_onehot;
  logic [NUM_STAGES-1:0] cur_d_onehot;
  logic                  cur_done;
  logic                  timed_out;

  // Lowest enabled stage of the incoming mask (descending scan keeps the lowest hit).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (cfg_stage_en[i]) begin
        first_found = 1'b1;
        first_idx   = SIDX_W'(i);
      end
    end
  end

  // Lowest latched-enabled stage strictly above the current one.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (en_q[i] && (i > int'(cur_stage))) begin
        next_found = 1'b1;
        next_idx   = SIDX_W'(i);
      end
    end
  end

  assign cur_onehot   = {{(NUM_STAGES-1){1'b0}}, 1'b1} << cur_stage;
  assign cur_d_onehot = {{(NUM_STAGES-1){1'b0}}, 1'b1} << cur_d;
  assign cur_done     = |(stage_done & cur_onehot);
  assign timed_out    = (timeout_q != '0) && (watchdog == (timeout_q - TIMEOUT_W'(1)));

  always_comb begin
    state_d      = state;
    cur_d        = cur_stage;
    err_stage_d  = err_stage;
    error_d      = error;
    en_d         = en_q;
    timeout_d    = timeout_q;
    watchdog_d   = watchdog;
    run_cycles_d = run_cycles;

    if (state != ST_IDLE && run_cycles != 32'hFFFF_FFFF) begin
      run_cycles_d = run_cycles + 32'd1;
    end

    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          en_d         = cfg_stage_en;
          timeout_d    = cfg_timeout;
          run_cycles_d = '0;
          error_d      = 1'b0;
          if (first_found) begin
            cur_d   = first_idx;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LAUNCH: begin
        watchdog_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        watchdog_d = watchdog + TIMEOUT_W'(1);
        // A completion in the same cycle as the timeout takes priority.
        if (cur_done) begin
          if (next_found) begin
            cur_d   = next_idx;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_FINISH;
          end
        end else if (timed_out) begin
          error_d     = 1'b1;
          err_stage_d = cur_stage;
          state_d     = ST_IDLE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything except the sticky error, which it leaves alone.
    if (state != ST_IDLE && abort) begin
      state_d     = ST_IDLE;
      cur_d       = cur_stage;
      error_d     = error;
      err_stage_d = err_stage;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_stage   <= '0;
      err_stage   <= '0;
      error       <= 1'b0;
      en_q        <= '0;
      timeout_q   <= '0;
      watchdog    <= '0;
      run_cycles  <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      cur_stage   <= cur_d;
      err_stage   <= err_stage_d;
      error       <= error_d;
      en_q        <= en_d;
      timeout_q   <= timeout_d;
      watchdog    <= watchdog_d;
      run_cycles  <= run_cycles_d;
      stage_start <= (state_d == ST_LAUNCH) ? cur_d_onehot : '0;
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_FINISH);
    end
  end

endmodule

// File: tb/tb_seg_stage_scheduler.sv
// Directed bench for seg_stage_scheduler: a table of whole runs plus hand-written
// sequences for mask-zero timing, abort, stray completions and asynchronous reset.
module tb_seg_stage_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  cfg_stage_en;
  logic [23:0] cfg_timeout;
  logic [3:0]  stage_done;
  logic [3:0]  stage_start;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_stage;
  logic [1:0]  cur_stage;
  logic [31:0] run_cycles;

  int passes = 0;
  int checks = 0;

  // Stage engine model: answers stage_start with a done pulse eng_delay cycles later.
  int         eng_delay = 3;
  logic [3:0] eng_hang  = '0;
  int         eng_cnt   = 0;
  int         eng_idx   = 0;
  logic [3:0] eng_done  = '0;
  logic [3:0] stray_done = '0;

  logic [31:0] start_log = '0;
  int          done_cnt  = 0;

  assign stage_done = eng_done | stray_done;

  always #5 clk = ~clk;

  seg_stage_scheduler #(
    .NUM_STAGES(4),
    .SIDX_W(2),
    .TIMEOUT_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg_stage_en(cfg_stage_en),
    .cfg_timeout(cfg_timeout),
    .stage_done(stage_done),
    .stage_start(stage_start),
    .busy(busy),
    .done(done),
    .error(error),
    .err_stage(err_stage),
    .cur_stage(cur_stage),
    .run_cycles(run_cycles)
  );

  always @(negedge clk) begin
    eng_done = '0;
    if (rst) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_hang[eng_idx]) eng_done[eng_idx] = 1'b1;
      end
      if (stage_start != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (stage_start[i]) eng_idx = i;
        eng_cnt = eng_delay;
      end
    end
  end

  always @(negedge clk) begin
    if (stage_start != 4'b0000) start_log = {start_log[27:0], stage_start};
    if (done) done_cnt++;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [23:0] timeout;
    int          delay;
    logic [3:0]  hang;
    logic [31:0] exp_log;
    int          exp_done;
    logic        exp_err;
    logic [1:0]  exp_err_stage;
    logic [1:0]  exp_cur;
    logic [31:0] exp_rc;
  } vec_t;

  vec_t vecs[8];

  task automatic apply_stimulus(input vec_t v, input int k);
    int n;
    @(negedge clk);
    cfg_stage_en = v.mask;
    cfg_timeout  = v.timeout;
    eng_delay    = v.delay;
    eng_hang     = v.hang;
    start_log    = '0;
    done_cnt     = 0;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    cfg_stage_en = '0;
    cfg_timeout  = '0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output($sformatf("v%0d run_ends", k), {31'd0, busy}, 32'd0);
    check_output($sformatf("v%0d start_order", k), start_log, v.exp_log);
    check_output($sformatf("v%0d done_pulses", k), done_cnt, v.exp_done);
    check_output($sformatf("v%0d error", k), {31'd0, error}, {31'd0, v.exp_err});
    check_output($sformatf("v%0d cur_stage", k), {30'd0, cur_stage}, {30'd0, v.exp_cur});
    check_output($sformatf("v%0d run_cycles", k), run_cycles, v.exp_rc);
    if (v.exp_err) check_output($sformatf("v%0d err_stage", k), {30'd0, err_stage}, {30'd0, v.exp_err_stage});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int n;
    // run_cycles = sum over launched stages of (1 + WAIT cycles) + 1 for FINISH.
    vecs[0] = '{4'b1111, 24'd0, 3, 4'b0000, 32'h0000_1248, 1, 1'b0, 2'd0, 2'd3, 32'd17};
    vecs[1] = '{4'b1010, 24'd0, 3, 4'b0000, 32'h0000_0028, 1, 1'b0, 2'd0, 2'd3, 32'd9};
    vecs[2] = '{4'b0011, 24'd4, 3, 4'b0010, 32'h0000_0012, 0, 1'b1, 2'd1, 2'd1, 32'd9};
    vecs[3] = '{4'b0011, 24'd0, 3, 4'b0000, 32'h0000_0012, 1, 1'b0, 2'd0, 2'd1, 32'd9};
    vecs[4] = '{4'b0011, 24'd4, 4, 4'b0000, 32'h0000_0012, 1, 1'b0, 2'd0, 2'd1, 32'd11};
    vecs[5] = '{4'b0001, 24'd1, 3, 4'b0001, 32'h0000_0001, 0, 1'b1, 2'd0, 2'd0, 32'd2};
    vecs[6] = '{4'b0100, 24'd5, 2, 4'b0000, 32'h0000_0004, 1, 1'b0, 2'd0, 2'd2, 32'd4};
    vecs[7] = '{4'b1000, 24'd3, 3, 4'b0000, 32'h0000_0008, 1, 1'b0, 2'd0, 2'd3, 32'd5};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_stage_en = '0;
    cfg_timeout = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset done", {31'd0, done}, 32'd0);
    check_output("reset error", {31'd0, error}, 32'd0);
    check_output("reset run_cycles", run_cycles, 32'd0);
    check_output("reset cur_stage", {30'd0, cur_stage}, 32'd0);
    check_output("reset err_stage", {30'd0, err_stage}, 32'd0);
    check_output("reset stage_start", {28'd0, stage_start}, 32'd0);

    // Empty mask: straight to FINISH, done one cycle after acceptance.
    cfg_stage_en = 4'b0000;
    start_log = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("mask0 done_at_T1", {31'd0, done}, 32'd1);
    check_output("mask0 busy_at_T1", {31'd0, busy}, 32'd1);
    check_output("mask0 no_stage_start", {28'd0, stage_start}, 32'd0);
    @(negedge clk);
    check_output("mask0 done_once", {31'd0, done}, 32'd0);
    check_output("mask0 idle", {31'd0, busy}, 32'd0);
    check_output("mask0 run_cycles", run_cycles, 32'd1);
    check_output("mask0 start_log", start_log, 32'd0);

    for (int k = 0; k < 8; k++) apply_stimulus(vecs[k], k);

    // start together with abort in IDLE is refused.
    @(negedge clk);
    cfg_stage_en = 4'b1111;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort busy", {31'd0, busy}, 32'd0);
    check_output("start_abort stage_start", {28'd0, stage_start}, 32'd0);

    // Abort during stage 2 WAIT, with a stray done and a busy start earlier in the run.
    @(negedge clk);
    cfg_stage_en = 4'b1111;
    cfg_timeout = 24'd0;
    eng_delay = 3;
    eng_hang = 4'b0000;
    start_log = '0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stray_done = 4'b0100;
    start = 1'b1;
    cfg_stage_en = 4'b0001;
    @(negedge clk);
    stray_done = 4'b0000;
    start = 1'b0;
    n = 0;
    while (stage_start != 4'b0100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("abort reach_stage2", {28'd0, stage_start}, 32'h4);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort busy", {31'd0, busy}, 32'd0);
    check_output("abort run_cycles", run_cycles, 32'd10);
    repeat (8) @(negedge clk);
    check_output("abort run_cycles_hold", run_cycles, 32'd10);
    check_output("abort start_order", start_log, 32'h0000_0124);
    check_output("abort no_done", done_cnt, 32'd0);
    check_output("abort error", {31'd0, error}, 32'd0);
    check_output("abort still_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset between edges during stage 1 WAIT.
    @(negedge clk);
    cfg_stage_en = 4'b0011;
    eng_delay = 3;
    start_log = '0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (stage_start != 4'b0010 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("rst reach_stage1", {28'd0, stage_start}, 32'h2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("rst busy_now", {31'd0, busy}, 32'd0);
    check_output("rst stage_start_now", {28'd0, stage_start}, 32'd0);
    check_output("rst run_cycles_now", run_cycles, 32'd0);
    check_output("rst cur_stage_now", {30'd0, cur_stage}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    eng_cnt = 0;
    repeat (6) @(negedge clk);
    check_output("rst no_more_starts", start_log, 32'h0000_0012);
    check_output("rst no_done", done_cnt, 32'd0);
    check_output("rst stays_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
